// File: rtl/mdu_pkg.sv
// Op encoding and issue classification for the multiply/divide unit.
// Optional MADD/MSUB support is controlled by the MDU_MADD_EN macro.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  // Ops that occupy the unit for a multi-cycle latency window
  function automatic logic is_timed(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_timed = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: is_timed = 1'b1;
`endif
      default: is_timed = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider: truncating quotient, remainder
// follows dividend sign, MIN/-1 saturates to MIN, zero divisor flagged.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_r;

  always_comb begin
    neg_a = is_signed & a[WIDTH-1];
    neg_b = is_signed & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    zero  = (b == '0);
    mag_q = '0;
    mag_r = mag_a;
    if (!zero) begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? -mag_q : mag_q;
    rem = neg_a ? -mag_r : mag_r;
    // Overflow case stated explicitly rather than relying on wraparound
    if (is_signed && (a == MIN_VAL) && (b == '1)) begin
      quo = MIN_VAL;
      rem = '0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit with HI/LO, busy-counter latency model and
// hazard stall. MDU_MADD_EN enables MADD/MSUB (ops 6/7).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned MAX_CY = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_CY + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;

  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    prod_u;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_zero;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [CW-1:0]    op_cycles;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .a         (a),
    .b         (b),
    .is_signed (op == OP_DIV),
    .quo       (div_quo),
    .rem       (div_rem),
    .zero      (div_zero)
  );

  assign stall = busy | (start & is_timed(op));

  // Result captured at acceptance; divide-by-zero keeps current HI/LO
  always_comb begin
    prod_s    = PW'($signed(a)) * PW'($signed(b));
    prod_u    = PW'(a) * PW'(b);
    op_cycles = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    res_hi    = hi;
    res_lo    = lo;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (!div_zero) begin
          res_hi = div_rem;
          res_lo = div_quo;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_timed(op)) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              count   <= op_cycles;
              busy    <= 1'b1;
              state   <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          // Any start seen here is dropped; hazard logic should prevent it
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
